// File: rtl/uart_alu_sequencer_pkg.sv
// Shared constants for the UART/ALU frame sequencer: FSM state encodings and ALU opcodes.
package uart_alu_sequencer_pkg;

    localparam logic [2:0] S_WAIT_A   = 3'd0;
    localparam logic [2:0] S_WAIT_B   = 3'd1;
    localparam logic [2:0] S_WAIT_OP  = 3'd2;
    localparam logic [2:0] S_EXEC     = 3'd3;
    localparam logic [2:0] S_TX_START = 3'd4;
    localparam logic [2:0] S_TX_WAIT  = 3'd5;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_NOR = 6'b100111;

    // States in which an incoming byte cannot be accepted.
    function automatic logic is_busy_state(input logic [2:0] state);
        return (state == S_EXEC) || (state == S_TX_START) || (state == S_TX_WAIT);
    endfunction

endpackage

// File: rtl/uart_alu_sequencer_frame_timer.sv
// Inter-byte timer: counts enabled cycles since the last clear and flags the final allowed cycle.
module uart_alu_sequencer_frame_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned NB_TIMER       = 17
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [NB_TIMER-1:0] LastCycle = NB_TIMER'(TIMEOUT_CYCLES - 1);

    logic [NB_TIMER-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (i_enable && (count_q != '1)) begin
            // Saturate instead of wrapping so a stuck enable can never re-arm a short timeout.
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_expired = (count_q == LastCycle);

endmodule

// File: rtl/uart_alu_sequencer.sv
// Frame sequencer between UART RX/TX and an external combinational ALU: collects A, B and opcode
// bytes, presents registered operands, latches the result and hands it to UART TX.
module uart_alu_sequencer
    import uart_alu_sequencer_pkg::*;
#(
    parameter int unsigned NB_DATA        = 8,
    parameter int unsigned NB_CODE        = 6,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned NB_TIMER       = 17
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_rx_done,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_tx_done,
    output logic [NB_DATA-1:0] o_data_a,
    output logic [NB_DATA-1:0] o_data_b,
    output logic [NB_CODE-1:0] o_code,
    output logic               o_tx_start,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_busy,
    output logic               o_frame_err,
    output logic               o_overrun
);

    logic [2:0]         state_q, state_d;
    logic [NB_DATA-1:0] data_a_q, data_a_d;
    logic [NB_DATA-1:0] data_b_q, data_b_d;
    logic [NB_CODE-1:0] code_q, code_d;
    logic [NB_DATA-1:0] tx_data_q, tx_data_d;
    logic               tx_start_q, tx_start_d;
    logic               busy_q, busy_d;
    logic               frame_err_q, frame_err_d;
    logic               overrun_q, overrun_d;

    logic timer_clear;
    logic timer_enable;
    logic timer_expired;

    uart_alu_sequencer_frame_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .NB_TIMER       (NB_TIMER)
    ) u_frame_timer (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_clear   (timer_clear),
        .i_enable  (timer_enable),
        .o_expired (timer_expired)
    );

    always_comb begin
        state_d      = state_q;
        data_a_d     = data_a_q;
        data_b_d     = data_b_q;
        code_d       = code_q;
        tx_data_d    = tx_data_q;
        frame_err_d  = 1'b0;
        overrun_d    = 1'b0;
        timer_clear  = 1'b0;
        timer_enable = 1'b0;

        case (state_q)
            S_WAIT_A: begin
                if (i_rx_done) begin
                    data_a_d    = i_rx_data;
                    timer_clear = 1'b1;
                    state_d     = S_WAIT_B;
                end
            end
            S_WAIT_B: begin
                // A byte arriving on the expiry cycle still counts as in time.
                if (i_rx_done) begin
                    data_b_d    = i_rx_data;
                    timer_clear = 1'b1;
                    state_d     = S_WAIT_OP;
                end else if (timer_expired) begin
                    frame_err_d = 1'b1;
                    timer_clear = 1'b1;
                    state_d     = S_WAIT_A;
                end else begin
                    timer_enable = 1'b1;
                end
            end
            S_WAIT_OP: begin
                if (i_rx_done) begin
                    code_d  = i_rx_data[NB_CODE-1:0];
                    state_d = S_EXEC;
                end else if (timer_expired) begin
                    frame_err_d = 1'b1;
                    timer_clear = 1'b1;
                    state_d     = S_WAIT_A;
                end else begin
                    timer_enable = 1'b1;
                end
            end
            S_EXEC: begin
                // Operands were registered on the previous edge, so the ALU output is settled.
                tx_data_d = i_alu_result;
                overrun_d = i_rx_done;
                state_d   = S_TX_START;
            end
            S_TX_START: begin
                overrun_d = i_rx_done;
                state_d   = S_TX_WAIT;
            end
            S_TX_WAIT: begin
                overrun_d = i_rx_done;
                if (i_tx_done) begin
                    state_d = S_WAIT_A;
                end
            end
            default: begin
                state_d     = S_WAIT_A;
                data_a_d    = '0;
                data_b_d    = '0;
                code_d      = '0;
                tx_data_d   = '0;
                timer_clear = 1'b1;
            end
        endcase

        tx_start_d = (state_d == S_TX_START);
        busy_d     = is_busy_state(state_d);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= S_WAIT_A;
            data_a_q    <= '0;
            data_b_q    <= '0;
            code_q      <= '0;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_a_q    <= data_a_d;
            data_b_q    <= data_b_d;
            code_q      <= code_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign o_data_a    = data_a_q;
    assign o_data_b    = data_b_q;
    assign o_code      = code_q;
    assign o_tx_start  = tx_start_q;
    assign o_tx_data   = tx_data_q;
    assign o_busy      = busy_q;
    assign o_frame_err = frame_err_q;
    assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Bench for uart_alu_sequencer: directed and randomized frames against a transaction-level model.
module tb_uart_alu_sequencer;

    localparam int unsigned NB_DATA = 8;
    localparam int unsigned NB_CODE = 6;
    localparam int unsigned TMO     = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               rx_done;
    logic [NB_DATA-1:0] rx_data;
    logic [NB_DATA-1:0] alu_result;
    logic               tx_done;
    logic [NB_DATA-1:0] data_a;
    logic [NB_DATA-1:0] data_b;
    logic [NB_CODE-1:0] code;
    logic               tx_start;
    logic [NB_DATA-1:0] tx_data;
    logic               busy;
    logic               frame_err;
    logic               overrun;

    int total = 0;
    int bad = 0;
    int starts_seen = 0;
    int starts_exp = 0;
    int errs_seen = 0;
    int errs_exp = 0;

    logic [5:0] op_table [8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                 6'b100110, 6'b000011, 6'b000010, 6'b100111};

    always #5 clk = ~clk;

    uart_alu_sequencer #(
        .NB_DATA        (NB_DATA),
        .NB_CODE        (NB_CODE),
        .TIMEOUT_CYCLES (TMO),
        .NB_TIMER       (17)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_rx_done    (rx_done),
        .i_rx_data    (rx_data),
        .i_alu_result (alu_result),
        .i_tx_done    (tx_done),
        .o_data_a     (data_a),
        .o_data_b     (data_b),
        .o_code       (code),
        .o_tx_start   (tx_start),
        .o_tx_data    (tx_data),
        .o_busy       (busy),
        .o_frame_err  (frame_err),
        .o_overrun    (overrun)
    );

    // Behavioural ALU: stands in for the real alu on the bench and also predicts results.
    function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
        logic signed [7:0] sa;
        sa = a;
        case (op)
            6'b100000: return a + b;
            6'b100010: return a - b;
            6'b100100: return a & b;
            6'b100101: return a | b;
            6'b100110: return a ^ b;
            6'b000011: return sa >>> b;
            6'b000010: return a >> b;
            6'b100111: return ~(a | b);
            default:   return 8'h00;
        endcase
    endfunction

    assign alu_result = ref_alu(data_a, data_b, code);

    always @(negedge clk) begin
        if (tx_start === 1'b1) starts_seen++;
        if (frame_err === 1'b1) errs_seen++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_done = 1'b1;
        rx_data = b;
        tick();
        rx_done = 1'b0;
        rx_data = 8'($urandom);
    endtask

    // Full frame with given inter-byte gaps; optionally an overrun byte while waiting for TX,
    // and optionally a byte colliding with tx_done.
    task automatic run_frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] op, input int gap1, input int gap2,
                             input bit ovr_wait, input bit ovr_with_done);
        logic [7:0] exp;
        exp = ref_alu(a, b, op[5:0]);
        send_byte(a);
        idle(gap1);
        send_byte(b);
        idle(gap2);
        send_byte(op);
        check_eq({tag, ".busy_exec"}, busy, 1);
        check_eq({tag, ".code"}, code, op[5:0]);
        check_eq({tag, ".start_early"}, tx_start, 0);
        tick();
        check_eq({tag, ".start"}, tx_start, 1);
        check_eq({tag, ".result"}, tx_data, exp);
        starts_exp++;
        tick();
        check_eq({tag, ".start_end"}, tx_start, 0);
        check_eq({tag, ".busy_wait"}, busy, 1);
        if (ovr_wait) begin
            send_byte(8'hAA);
            check_eq({tag, ".ovr"}, overrun, 1);
            check_eq({tag, ".ovr_data"}, tx_data, exp);
            check_eq({tag, ".ovr_busy"}, busy, 1);
            tick();
            check_eq({tag, ".ovr_end"}, overrun, 0);
        end
        idle($urandom_range(0, 3));
        tx_done = 1'b1;
        if (ovr_with_done) begin
            rx_done = 1'b1;
            rx_data = 8'hAA;
        end
        tick();
        tx_done = 1'b0;
        rx_done = 1'b0;
        check_eq({tag, ".idle"}, busy, 0);
        check_eq({tag, ".ovr_done"}, overrun, ovr_with_done);
        check_eq({tag, ".a"}, data_a, a);
        check_eq({tag, ".b"}, data_b, b);
        tick();
    endtask

    // Partial frame then silence: error pulse exactly TMO cycles after the last accepted byte.
    task automatic run_timeout(input string tag, input int nbytes);
        send_byte(8'h11);
        if (nbytes > 1) send_byte(8'($urandom));
        idle(TMO - 1);
        check_eq({tag, ".no_err_yet"}, frame_err, 0);
        tick();
        check_eq({tag, ".err"}, frame_err, 1);
        check_eq({tag, ".err_busy"}, busy, 0);
        errs_exp++;
        tick();
        check_eq({tag, ".err_end"}, frame_err, 0);
    endtask

    initial begin
        rst     = 1'b1;
        rx_done = 1'b0;
        rx_data = '0;
        tx_done = 1'b0;
        idle(2);
        check_eq("rst.a", data_a, 0);
        check_eq("rst.b", data_b, 0);
        check_eq("rst.code", code, 0);
        check_eq("rst.txd", tx_data, 0);
        check_eq("rst.flags", {tx_start, busy, frame_err, overrun}, 0);
        rst = 1'b0;
        tick();

        run_frame("add", 8'h05, 8'h03, 8'h20, 0, 0, 1'b0, 1'b0);
        run_frame("sub", 8'h05, 8'h07, 8'h22, 1, 2, 1'b0, 1'b0);
        run_frame("or", 8'hF0, 8'h0F, 8'h25, 0, 0, 1'b1, 1'b0);

        run_timeout("tmo1", 1);
        run_frame("after_tmo", 8'h01, 8'h01, 8'h20, 0, 0, 1'b0, 1'b0);
        run_timeout("tmo2", 2);

        run_frame("collide", 8'h33, 8'h11, 8'h26, 0, 0, 1'b0, 1'b1);

        // Asynchronous reset mid-frame, applied between clock edges.
        send_byte(8'h09);
        send_byte(8'h04);
        #2 rst = 1'b1;
        #1;
        check_eq("async.a", data_a, 0);
        check_eq("async.b", data_b, 0);
        check_eq("async.busy", busy, 0);
        tick();
        rst = 1'b0;
        tick();
        run_frame("post_rst", 8'h02, 8'h02, 8'h20, 0, 0, 1'b0, 1'b0);

        // High opcode bits ignored; bytes on the exact expiry cycle accepted.
        run_frame("edge", 8'h10, 8'h22, 8'hE0, TMO - 1, TMO - 1, 1'b0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                run_timeout("rnd_tmo", int'($urandom_range(1, 2)));
            end else begin
                run_frame("rnd", 8'($urandom), 8'($urandom),
                          {2'($urandom), op_table[$urandom_range(0, 7)]},
                          int'($urandom_range(0, TMO - 1)), int'($urandom_range(0, TMO - 1)),
                          1'($urandom), 1'($urandom));
            end
        end

        idle(2);
        check_eq("start_count", starts_seen, starts_exp);
        check_eq("err_count", errs_seen, errs_exp);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
